// File: rtl/mem_port_arbiter.sv
// Shared OBI-style memory port: fetch and data access take turns
// on one bus, one transaction in flight, data first unless fetch starves.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              imem_req_i,
  input  logic [ADDR_W-1:0] imem_addr_i,
  output logic              imem_gnt_o,
  output logic              imem_rvalid_o,
  output logic [DATA_W-1:0] imem_rdata_o,
  input  logic              dmem_req_i,
  input  logic              dmem_we_i,
  input  logic [DATA_W/8-1:0] dmem_be_i,
  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic [DATA_W-1:0] dmem_wdata_i,
  output logic              dmem_gnt_o,
  output logic              dmem_rvalid_o,
  output logic [DATA_W-1:0] dmem_rdata_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [DATA_W/8-1:0] bus_be_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              imem_stall_o,
  output logic              dmem_stall_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W =
    (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam bit STARVE_EN = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IMEM,
    OWN_DMEM
  } owner_e;

  state_e            state_q;
  owner_e            owner_q;
  logic              bubble_q;
  logic [CNT_W-1:0]  starve_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic arb_en;
  logic force_imem;
  logic pick_imem;
  logic rsp;

  // Arbitrate only in a non-bubble IDLE cycle; starved fetch overrides data.
  always_comb begin
    arb_en = rst_ni & (state_q == IDLE) & ~bubble_q
           & (imem_req_i | dmem_req_i);
    force_imem = STARVE_EN & imem_req_i & (starve_q == LIMIT);
    pick_imem  = imem_req_i & (~dmem_req_i | force_imem);
    rsp = rst_ni & (state_q == RESP) & bus_rvalid_i;
  end

  // Bus fields: winner's live fields while arbitrating, latched in ADDR.
  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_be_o    = '0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    if (arb_en) begin
      bus_req_o = 1'b1;
      if (pick_imem) begin
        bus_be_o   = '1;
        bus_addr_o = imem_addr_i;
      end else begin
        bus_we_o    = dmem_we_i;
        bus_be_o    = dmem_be_i;
        bus_addr_o  = dmem_addr_i;
        bus_wdata_o = dmem_wdata_i;
      end
    end else if (rst_ni && state_q == ADDR) begin
      bus_req_o   = 1'b1;
      bus_we_o    = we_q;
      bus_be_o    = be_q;
      bus_addr_o  = addr_q;
      bus_wdata_o = wdata_q;
    end
  end

  // Requester handshakes, response routing and stall signals.
  always_comb begin
    imem_gnt_o = bus_gnt_i & bus_req_o
               & (arb_en ? pick_imem : (owner_q == OWN_IMEM));
    dmem_gnt_o = bus_gnt_i & bus_req_o
               & (arb_en ? ~pick_imem : (owner_q == OWN_DMEM));
    imem_rvalid_o = rsp & (owner_q == OWN_IMEM);
    dmem_rvalid_o = rsp & (owner_q == OWN_DMEM);
    imem_rdata_o  = imem_rvalid_o ? bus_rdata_i : '0;
    dmem_rdata_o  = dmem_rvalid_o ? bus_rdata_i : '0;
    imem_stall_o = rst_ni & ~imem_rvalid_o
                 & (imem_req_i | (owner_q == OWN_IMEM));
    dmem_stall_o = rst_ni & ~dmem_rvalid_o
                 & (dmem_req_i | (owner_q == OWN_DMEM));
  end

  // Transaction FSM, owner/field latches and starvation counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      bubble_q <= 1'b0;
      starve_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      bubble_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb_en) begin
            owner_q <= pick_imem ? OWN_IMEM : OWN_DMEM;
            we_q    <= bus_we_o;
            be_q    <= bus_be_o;
            addr_q  <= bus_addr_o;
            wdata_q <= bus_wdata_o;
            state_q <= bus_gnt_i ? RESP : ADDR;
            if (!pick_imem && imem_req_i) begin
              if (starve_q != LIMIT) starve_q <= starve_q + 1'b1;
            end else begin
              starve_q <= '0;
            end
          end
        end
        ADDR: begin
          if (bus_gnt_i) state_q <= RESP;
        end
        RESP: begin
          if (bus_rvalid_i) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            bubble_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          owner_q <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table plus
// sequences for delayed grant, starvation and reset mid-transaction.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_i = 1'b0;
  logic [31:0] imem_addr_i = '0;
  logic        imem_gnt_o, imem_rvalid_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_req_i = 1'b0;
  logic        dmem_we_i = 1'b0;
  logic [3:0]  dmem_be_i = 4'hF;
  logic [31:0] dmem_addr_i = '0;
  logic [31:0] dmem_wdata_i = '0;
  logic        dmem_gnt_o, dmem_rvalid_o;
  logic [31:0] dmem_rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        imem_stall_o, dmem_stall_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
    .imem_gnt_o(imem_gnt_o), .imem_rvalid_o(imem_rvalid_o),
    .imem_rdata_o(imem_rdata_o),
    .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i),
    .dmem_be_i(dmem_be_i), .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i),
    .dmem_gnt_o(dmem_gnt_o), .dmem_rvalid_o(dmem_rvalid_o),
    .dmem_rdata_o(dmem_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i),
    .imem_stall_o(imem_stall_o), .dmem_stall_o(dmem_stall_o)
  );

  // {req, we, ignt, irvalid, dgnt, drvalid, istall, dstall}
  wire [7:0] flags = {bus_req_o, bus_we_o, imem_gnt_o, imem_rvalid_o,
                      dmem_gnt_o, dmem_rvalid_o, imem_stall_o, dmem_stall_o};

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic [7:0]  ef;
    logic [31:0] ea;
    logic [31:0] eir;
    logic [31:0] edr;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da,
    input logic g, input logic rv, input logic [31:0] rd,
    input logic [7:0] ef, input logic [31:0] ea,
    input logic [31:0] eir, input logic [31:0] edr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.g = g; v.rv = rv; v.rd = rd;
    v.ef = ef; v.ea = ea; v.eir = eir; v.edr = edr;
    return v;
  endfunction

  vec_t tbl[16];
  int   ng;
  int   gcount;
  logic prev_gnt;

  initial begin
    tbl[0]  = mk(0, 0,      0, 0, 0,      0, 0, 0,
                 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 'h100,  0, 0, 0,      1, 0, 0,
                 8'b1010_0010, 'h100, 0, 0);
    tbl[2]  = mk(0, 0,      0, 0, 0,      0, 1, 'hDEADBEEF,
                 8'b0001_0000, 0, 'hDEADBEEF, 0);
    tbl[3]  = mk(0, 0,      0, 0, 0,      0, 0, 0,
                 8'h00, 0, 0, 0);
    tbl[4]  = mk(1, 'h200,  1, 0, 'h300,  1, 0, 0,
                 8'b1000_1011, 'h300, 0, 0);
    tbl[5]  = mk(1, 'h200,  0, 0, 0,      0, 1, 'h12345678,
                 8'b0000_0110, 0, 0, 'h12345678);
    tbl[6]  = mk(1, 'h200,  0, 0, 0,      1, 0, 0,
                 8'b0000_0010, 0, 0, 0);
    tbl[7]  = mk(1, 'h200,  0, 0, 0,      1, 0, 0,
                 8'b1010_0010, 'h200, 0, 0);
    tbl[8]  = mk(0, 0,      0, 0, 0,      0, 1, 'hCAFEF00D,
                 8'b0001_0000, 0, 'hCAFEF00D, 0);
    tbl[9]  = mk(0, 0,      0, 0, 0,      0, 0, 0,
                 8'h00, 0, 0, 0);
    tbl[10] = mk(0, 0,      0, 0, 0,      0, 1, 'h55,
                 8'h00, 0, 0, 0);
    tbl[11] = mk(0, 0,      1, 1, 'h400,  0, 1, 'h66,
                 8'b1100_0001, 'h400, 0, 0);
    tbl[12] = mk(0, 0,      1, 1, 'h400,  0, 1, 'h77,
                 8'b1100_0001, 'h400, 0, 0);
    tbl[13] = mk(0, 0,      1, 1, 'h400,  1, 0, 0,
                 8'b1100_1001, 'h400, 0, 0);
    tbl[14] = mk(0, 0,      0, 0, 0,      0, 1, 'hAAAA0000,
                 8'b0000_0100, 0, 0, 'hAAAA0000);
    tbl[15] = mk(0, 0,      0, 0, 0,      0, 0, 0,
                 8'h00, 0, 0, 0);

    // outputs must stay 0 in reset even with live requests
    imem_req_i = 1; dmem_req_i = 1; bus_gnt_i = 1; bus_rvalid_i = 1;
    imem_addr_i = 'h10; dmem_addr_i = 'h20;
    #2;
    chk("rst_flags", {24'b0, flags}, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_rdata", imem_rdata_o | dmem_rdata_o, 0);
    @(negedge clk);
    imem_req_i = 0; dmem_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0;
    rst_n = 1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      imem_req_i   = tbl[i].ir;
      imem_addr_i  = tbl[i].ia;
      dmem_req_i   = tbl[i].dr;
      dmem_we_i    = tbl[i].dw;
      dmem_addr_i  = tbl[i].da;
      bus_gnt_i    = tbl[i].g;
      bus_rvalid_i = tbl[i].rv;
      bus_rdata_i  = tbl[i].rd;
      #1;
      chk($sformatf("v%0d_flags", i), {24'b0, flags}, {24'b0, tbl[i].ef});
      chk($sformatf("v%0d_addr", i), bus_addr_o, tbl[i].ea);
      chk($sformatf("v%0d_irdata", i), imem_rdata_o, tbl[i].eir);
      chk($sformatf("v%0d_drdata", i), dmem_rdata_o, tbl[i].edr);
    end

    // store with grant delayed 3 cycles; fields latched despite input churn
    @(negedge clk);
    imem_req_i = 0; dmem_req_i = 1; dmem_we_i = 1; dmem_be_i = 4'b0011;
    dmem_addr_i = 'h500; dmem_wdata_i = 'h11223344;
    bus_rvalid_i = 0;
    gcount = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        dmem_addr_i  = 32'hFFFF_0000 + c;
        dmem_wdata_i = 32'hFFFF_FFFF;
        dmem_be_i    = 4'hC;
      end
      bus_gnt_i = (c == 3);
      #1;
      chk($sformatf("st%0d_req", c), {31'b0, bus_req_o}, 1);
      chk($sformatf("st%0d_we", c), {31'b0, bus_we_o}, 1);
      chk($sformatf("st%0d_be", c), {28'b0, bus_be_o}, 'h3);
      chk($sformatf("st%0d_addr", c), bus_addr_o, 'h500);
      chk($sformatf("st%0d_wdata", c), bus_wdata_o, 'h11223344);
      chk($sformatf("st%0d_gnt", c), {31'b0, dmem_gnt_o}, (c == 3) ? 1 : 0);
      gcount += int'(dmem_gnt_o);
    end
    chk("st_gnt_count", gcount, 1);
    @(negedge clk);
    dmem_req_i = 0; dmem_we_i = 0; dmem_be_i = 4'hF; dmem_wdata_i = 0;
    dmem_addr_i = 0; bus_gnt_i = 0;
    #1;
    chk("st_resp_wait", {24'b0, flags}, 8'b0000_0001);
    @(negedge clk);
    bus_rvalid_i = 1; bus_rdata_i = 0;
    #1;
    chk("st_rvalid", {24'b0, flags}, 8'b0000_0100);
    @(negedge clk);
    bus_rvalid_i = 0;
    #1;
    chk("st_idle", {24'b0, flags}, 0);

    // starvation: expect D D D D I D
    imem_req_i = 1; imem_addr_i = 'h600;
    dmem_req_i = 1; dmem_addr_i = 'h700;
    bus_gnt_i = 1;
    ng = 0;
    prev_gnt = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      @(negedge clk);
      bus_rvalid_i = prev_gnt;
      #1;
      if (imem_gnt_o || dmem_gnt_o) begin
        chk($sformatf("starve_onehot%0d", ng),
            {31'b0, imem_gnt_o & dmem_gnt_o}, 0);
        chk($sformatf("starve_gnt%0d_imem", ng),
            {31'b0, imem_gnt_o}, (ng == 4) ? 1 : 0);
        ng++;
      end
      prev_gnt = imem_gnt_o | dmem_gnt_o;
    end
    chk("starve_grants", ng, 6);
    @(negedge clk);
    imem_req_i = 0; dmem_req_i = 0; bus_gnt_i = 0;
    bus_rvalid_i = prev_gnt;
    @(negedge clk);
    bus_rvalid_i = 0;
    @(negedge clk);
    #1;
    chk("starve_idle", {24'b0, flags}, 0);

    // reset during RESP, stray rvalid afterwards
    @(negedge clk);
    dmem_req_i = 1; dmem_addr_i = 'h800; bus_gnt_i = 1;
    #1;
    chk("rr_gnt", {24'b0, flags}, 8'b1000_1001);
    @(negedge clk);
    rst_n = 0; imem_req_i = 1; bus_rvalid_i = 1; bus_rdata_i = 'h99;
    #1;
    chk("rr_in_reset", {24'b0, flags}, 0);
    chk("rr_in_reset_rd", dmem_rdata_o | imem_rdata_o, 0);
    @(negedge clk);
    rst_n = 1; imem_req_i = 0; dmem_req_i = 0; bus_gnt_i = 0;
    #1;
    chk("rr_stray", {24'b0, flags}, 0);
    chk("rr_stray_rd", dmem_rdata_o | imem_rdata_o, 0);
    @(negedge clk);
    bus_rvalid_i = 0; imem_req_i = 1; imem_addr_i = 'h900; bus_gnt_i = 1;
    #1;
    chk("rr_new_flags", {24'b0, flags}, 8'b1010_0010);
    chk("rr_new_addr", bus_addr_o, 'h900);
    @(negedge clk);
    imem_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 'h0BADF00D;
    #1;
    chk("rr_new_rvalid", {24'b0, flags}, 8'b0001_0000);
    chk("rr_new_rdata", imem_rdata_o, 'h0BADF00D);
    @(negedge clk);
    bus_rvalid_i = 0;
    #1;
    chk("rr_idle", {24'b0, flags}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
